// File: rtl/branch_redirect_ctrl.sv
// Branch resolution and front-end redirect sequencer for a pipelined core.
// Latency: result pulse and redirect appear the cycle after an op is accepted.
// Backpressure: req_ready drops for the whole redirect + flush window; redirect is held until redirect_ready.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         EX handshake for one resolved control-transfer op
//   is_jal, is_jalr, func3      op kind (both kind flags 0 = conditional branch)
//   pc, imm, rs1_data, rs2_data op PC, sign-extended immediate, operands
//   res_valid/taken/misalign    one-cycle result of the accepted op
//   redirect_valid/pc/ready     corrected next PC towards fetch
//   flush                       kill younger instructions in IF/ID
//   mispredict_cnt              saturating count of mispredicted ops
module branch_redirect_ctrl #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          is_jal,
  input  logic          is_jalr,
  input  logic [2:0]    func3,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] imm,
  input  logic [DW-1:0] rs1_data,
  input  logic [DW-1:0] rs2_data,
  output logic          res_valid,
  output logic          res_taken,
  output logic          res_misalign,
  output logic          redirect_valid,
  output logic [AW-1:0] redirect_pc,
  input  logic          redirect_ready,
  output logic          flush,
  output logic [CW-1:0] mispredict_cnt
);

  // Counter only has to hold FLUSH_CYCLES-1.
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REDIR, FLUSH} state_t;

  state_t         state_q, state_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;

  logic          op_jalr, op_jal, op_br;
  logic          cond, taken, mispred, accept;
  logic [AW-1:0] br_tgt, jalr_sum, target, pc_plus4, actual_pc, pred_pc;

  // JALR wins when both kind flags are set.
  assign op_jalr = is_jalr;
  assign op_jal  = is_jal && !is_jalr;
  assign op_br   = !is_jal && !is_jalr;

  always_comb begin
    cond = 1'b0;
    case (func3)
      3'b000:  cond = (rs1_data == rs2_data);
      3'b001:  cond = (rs1_data != rs2_data);
      3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  cond = (rs1_data <  rs2_data);
      3'b111:  cond = (rs1_data >= rs2_data);
      default: cond = 1'b0;
    endcase
  end

  assign taken     = op_br ? cond : 1'b1;
  assign br_tgt    = pc + imm;
  assign jalr_sum  = AW'(rs1_data) + imm;
  assign target    = op_jalr ? (jalr_sum & ~AW'(1)) : br_tgt;
  assign pc_plus4  = pc + AW'(4);
  assign actual_pc = taken ? target : pc_plus4;

  // Static BTFN: backward branches and JAL predicted taken, JALR predicted fall-through.
  always_comb begin
    pred_pc = pc_plus4;
    if (op_jal || (op_br && imm[AW-1])) pred_pc = br_tgt;
  end

  assign mispred   = (actual_pc != pred_pc);
  assign req_ready = rst_n && (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && mispred) state_d = REDIR;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        if (redirect_ready) begin
          state_d = FLUSH;
          fcnt_d  = FCW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (fcnt_q == '0) state_d = IDLE;
        else              fcnt_d  = fcnt_q - FCW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      fcnt_q         <= '0;
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_misalign   <= 1'b0;
      redirect_pc    <= '0;
      mispredict_cnt <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      res_valid <= accept;
      if (accept) begin
        res_taken    <= taken;
        res_misalign <= taken && target[1];
        if (mispred) begin
          // redirect_pc only moves on acceptance, so it stays frozen through REDIR.
          redirect_pc <= actual_pc;
          if (mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Branch resolution and front-end redirect sequencer for the pipelined core.
- Accepts one resolved control-transfer op per handshake from EX: conditional branch, JAL or JALR.
- Evaluates the branch condition, signed or unsigned as func3 requires, and computes the actual next PC.
- Compares the actual next PC with the static BTFN prediction.
- On mismatch, drives a held redirect to fetch and a counted pipeline flush, and blocks new ops until the flush completes.

Parameters:
AW, 32, address/PC width
DW, 32, register data width
FLUSH_CYCLES, 2, cycles flush stays asserted after redirect accepted (>=1)
CW, 16, width of saturating mispredict counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  EX presents a control-transfer op
req_ready  out  1  block can accept op this cycle
is_jal  in  1  op is JAL
is_jalr  in  1  op is JALR (is_jal and is_jalr both 0 = conditional branch)
func3  in  3  branch func3 (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu)
pc  in  AW  PC of the op
imm  in  AW  sign-extended immediate
rs1_data  in  DW  operand 1
rs2_data  in  DW  operand 2
res_valid  out  1  one-cycle pulse: result of accepted op
res_taken  out  1  op was taken (valid with res_valid)
res_misalign  out  1  taken target bit[1] set (valid with res_valid)
redirect_valid  out  1  fetch must restart at redirect_pc
redirect_pc  out  AW  corrected next PC
redirect_ready  in  1  fetch accepts redirect
flush  out  1  kill younger instructions in IF/ID
mispredict_cnt  out  CW  saturating mispredict count

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE. All of the following are 0: req_ready, res_valid, res_taken, res_misalign, redirect_valid, redirect_pc, flush, mispredict_cnt. Reset takes priority over every event, including mid-REDIR and mid-FLUSH.
- Accept: an op is accepted on a cycle with req_valid && req_ready. req_ready=1 only in IDLE and not in the reset cycle.
- Condition evaluation:
  - beq/bne: equality compare.
  - blt/bge: signed compare.
  - bltu/bgeu: unsigned compare.
  - func3 010/011: not taken.
  - JAL and JALR: always taken.
- Target computation:
  - Branch and JAL: pc+imm.
  - JALR: (rs1_data+imm) with bit0 cleared.
  - All adds are modulo 2^AW; wrap-around is silent.
  - Fall-through is pc+4, modulo 2^AW.
- Actual next PC = taken ? target : pc+4.
- Prediction (BTFN):
  - Conditional branch: predicted taken iff imm[AW-1]=1 (backward); predicted next = pc+imm.
  - JAL: predicted taken, next = pc+imm.
  - JALR: predicted next = pc+4.
- Mispredict = actual next PC != predicted next PC.
- Cycle after accept:
  - res_valid=1 for exactly one cycle, with registered res_taken.
  - res_misalign = taken && target[1].
- On mispredict:
  - In the cycle after accept, state goes to REDIR, with redirect_valid=1, redirect_pc=actual next PC and flush=1.
  - mispredict_cnt increments by 1, saturating at 2^CW-1.
- No mispredict: state stays IDLE; back-to-back accepts are allowed every cycle.
- REDIR:
  - redirect_valid, redirect_pc and flush are held stable until redirect_ready=1.
  - On the cycle with redirect_valid && redirect_ready, go to FLUSH and load the counter with FLUSH_CYCLES-1.
- FLUSH:
  - flush=1 and redirect_valid=0.
  - The counter decrements each cycle; when it reaches 0, return to IDLE.
  - Total flush cycles after the handshake = FLUSH_CYCLES.
- req_ready=0 throughout REDIR and FLUSH. req_valid is ignored in those states; EX must hold the op.
- Misaligned taken target still redirects normally; trap handling is done elsewhere from res_misalign.
- If is_jal and is_jalr are both 1, the op is treated as JALR.

Test Plan:
1. Backward beq taken: pc=0x100, imm=0xFFFFFFF0, rs1=rs2=5. Required: res_valid pulse, res_taken=1, no redirect, mispredict_cnt=0, req_ready stays 1.
2. Forward blt signed taken: pc=0x200, imm=0x20, rs1=0xFFFFFFFF, rs2=1. Required: next cycle redirect_valid=1, redirect_pc=0x220, flush=1, mispredict_cnt=1.
3. bltu not taken: rs1=0xFFFFFFFF, rs2=1, backward imm=0xFFFFFFF8, pc=0x300. Required: res_taken=0, redirect_pc=0x304.
4. JALR: rs1=0x1003, imm=0x4, pc=0x40. Required: redirect_pc=0x1006, res_misalign=1; with FLUSH_CYCLES=2, flush high for the REDIR cycles plus exactly 2 cycles after the handshake, then req_ready returns to 1.
5. redirect_ready held low 3 cycles during REDIR, with req_valid=1 throughout. Required: redirect_valid/redirect_pc stable, req_ready=0, no second accept, res_valid not re-pulsed.
6. rst_n low during FLUSH. Required: next edge, all outputs 0 and state IDLE; a subsequent correctly-predicted op is accepted normally. Separately, with CW=2, after 5 mispredicts mispredict_cnt=3 (saturated).
